// File: rtl/s_ram_pkg.sv
// -----------------------------------------------------------------------------
// s_ram_pkg
// Shared definitions for the s_RAM path: RAM geometry, the byte type used by
// the init FSM and later stages, the state encoding of the read-back sweep FSM,
// and a small helper used by the read-back checksum logic.
// -----------------------------------------------------------------------------
package s_ram_pkg;

  // s_RAM geometry: 256 bytes, 8-bit address.
  localparam int S_RAM_DEPTH = 256;
  localparam int S_RAM_AW    = 8;

  typedef logic [7:0] byte_t;

  // States of the s_RAM read-back sweep.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5
  } rd_state_e;

  // 1 when the byte stored at a location differs from its own address,
  // i.e. the identity initialisation s[i] = i did not hold there.
  function automatic logic byte_differs(input byte_t data, input byte_t addr);
    return (data != addr);
  endfunction

endpackage : s_ram_pkg

// File: rtl/ram_rd_wait.sv
// -----------------------------------------------------------------------------
// ram_rd_wait
// Read-latency timer for the s_RAM read port. A one-cycle request strobe,
// issued in the cycle the address is first presented, starts a down-counter.
// q_valid_next pulses for exactly one cycle: the cycle after which the RAM
// output q carries the data for that address (RD_LAT cycles after req).
//
// Ports:
//   clock        in  system clock (posedge)
//   reset        in  asynchronous, active-high
//   req          in  one-cycle request strobe (address presented this cycle)
//   q_valid_next out q holds the requested data on the next cycle
// -----------------------------------------------------------------------------
module ram_rd_wait #(
  parameter int RD_LAT = 1   // legal 1..3
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  output logic q_valid_next
);

  // Counter is loaded with RD_LAT-1 on req; it reaches 1 in the last wait cycle.
  localparam logic [1:0] LAT_M1  = 2'(RD_LAT - 1);
  localparam logic       LAT_ONE = (RD_LAT == 1);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // Next-count: load on request, count down to zero and park there.
  always_comb begin
    cnt_d = cnt_q;
    if (req) begin
      cnt_d = LAT_M1;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A single-cycle latency has no wait cycles, so the strobe coincides with req.
  assign q_valid_next = req ? LAT_ONE : (cnt_q == 2'd1);

endmodule : ram_rd_wait

// File: rtl/s_ram_reader.sv
// -----------------------------------------------------------------------------
// s_ram_reader
// Sweeps s_RAM addresses 0..LAST_ADDR after initialisation and streams every
// byte out on a valid/ready interface, together with the address it came
// from. While sweeping it accumulates a mod-256 sum, an XOR checksum and the
// number of locations where s[i] != i. Results hold until the next start.
//
// Ports:
//   clock      in   system clock (posedge)
//   reset      in   asynchronous, active-high; clears all state
//   start      in   begin a sweep (only looked at while idle)
//   finish     out  one-cycle pulse when the sweep is complete
//   busy       out  high whenever the FSM is not idle
//   address    out  s_RAM read address
//   wren       out  s_RAM write enable, always 0
//   q          in   s_RAM read data (RD_LAT cycles after address)
//   out_data   out  byte read from s_RAM
//   out_addr   out  address out_data came from
//   out_valid  out  out_data/out_addr valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   sum        out  mod-256 sum of bytes read this sweep
//   xsum       out  XOR of bytes read this sweep
//   mismatch   out  count of locations with s[i] != i (0..256)
// -----------------------------------------------------------------------------
module s_ram_reader
  import s_ram_pkg::*;
#(
  parameter int                    RD_LAT    = 1,      // legal 1..3
  parameter logic [S_RAM_AW-1:0]   LAST_ADDR = 8'd255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                finish,
  output logic                busy,
  output logic [S_RAM_AW-1:0] address,
  output logic                wren,
  input  logic [7:0]          q,
  output logic [7:0]          out_data,
  output logic [S_RAM_AW-1:0] out_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          sum,
  output logic [7:0]          xsum,
  output logic [8:0]          mismatch
);

  rd_state_e   state_q,     state_d;
  byte_t       address_q,   address_d;
  byte_t       out_data_q,  out_data_d;
  byte_t       out_addr_q,  out_addr_d;
  byte_t       sum_q,       sum_d;
  byte_t       xsum_q,      xsum_d;
  logic [8:0]  mismatch_q,  mismatch_d;
  logic        out_valid_q, out_valid_d;
  logic        finish_q,    finish_d;
  logic        busy_q,      busy_d;

  logic        rd_req_s;
  logic        q_valid_next_s;

  // The address is first presented in REQ, so that is where the latency timer starts.
  assign rd_req_s = (state_q == ST_REQ);

  ram_rd_wait #(
    .RD_LAT (RD_LAT)
  ) u_rd_wait (
    .clock        (clock),
    .reset        (reset),
    .req          (rd_req_s),
    .q_valid_next (q_valid_next_s)
  );

  // Next-state, datapath updates and output decode of the sweep FSM.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    sum_d      = sum_q;
    xsum_d     = xsum_q;
    mismatch_d = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          address_d  = 8'd0;
          sum_d      = 8'd0;
          xsum_d     = 8'd0;
          mismatch_d = 9'd0;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (q_valid_next_s) begin
          state_d = ST_CAPT;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (q_valid_next_s) begin
          state_d = ST_CAPT;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_CAPT: begin
        // q is valid for address_q in this cycle; address has not moved since REQ.
        out_data_d = q;
        out_addr_d = address_q;
        sum_d      = sum_q + q;
        xsum_d     = xsum_q ^ q;
        mismatch_d = mismatch_q + {8'd0, byte_differs(q, address_q)};
        state_d    = ST_HOLD;
      end

      ST_HOLD: begin
        if (out_ready) begin
          // Stop at LAST_ADDR instead of incrementing so the counter never wraps.
          if (address_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            address_d = address_q + 8'd1;
            state_d   = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flag outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    out_valid_d = (state_d == ST_HOLD);
    finish_d    = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      address_q   <= 8'd0;
      out_data_q  <= 8'd0;
      out_addr_q  <= 8'd0;
      sum_q       <= 8'd0;
      xsum_q      <= 8'd0;
      mismatch_q  <= 9'd0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      sum_q       <= sum_d;
      xsum_q      <= xsum_d;
      mismatch_q  <= mismatch_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
    end
  end

  assign address   = address_q;
  assign wren      = 1'b0;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign finish    = finish_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign xsum      = xsum_q;
  assign mismatch  = mismatch_q;

endmodule : s_ram_reader
